// File: rtl/latch_sched_pkg.sv
// Shared types and elaboration helpers for the latch bank write scheduler.
// Used by latch_bank_sched and latch_sched_rr_arb.
package latch_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } state_e;

    // Smallest legal gate-high and post-gate hold lengths, in cycles.
    localparam int MIN_PULSE_CYC = 1;
    localparam int MIN_HOLD_CYC  = 1;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int at_least(input int v, input int lo);
        return (v < lo) ? lo : v;
    endfunction

    function automatic int cnt_w(input int p, input int h);
        int m;
        m = (p > h) ? p : h;
        return (m + 1 > 1) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/latch_sched_rr_arb.sv
// Combinational requester picker: round-robin from ptr_i by default, or
// lowest-index fixed priority when LATCH_SCHED_FIXED_PRIO_EN is defined.
module latch_sched_rr_arb
    import latch_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]          req_i,
    input  logic [grant_w(NREQ)-1:0] ptr_i,
    output logic                     gnt_valid_o,
    output logic [grant_w(NREQ)-1:0] gnt_idx_o
);
    localparam int GW = grant_w(NREQ);

`ifdef LATCH_SCHED_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = GW'(i);
            end
        end
    end
`else
    logic [NREQ-1:0] rot;
    logic [GW:0]     sum;

    // rot[j] is the request sitting j positions after the pointer; scanning
    // downward leaves the nearest one as the final assignment.
    always_comb begin
        rot         = NREQ'({req_i, req_i} >> ptr_i);
        sum         = '0;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                sum = {1'b0, ptr_i} + (GW + 1)'(j);
                if (sum >= (GW + 1)'(NREQ)) begin
                    sum = sum - (GW + 1)'(NREQ);
                end
                gnt_valid_o = 1'b1;
                gnt_idx_o   = sum[GW-1:0];
            end
        end
    end
`endif

endmodule

// File: rtl/latch_bank_sched.sv
// Write scheduler for a bank of gated D latches: arbitrate, then setup / gate pulse / hold / ack.
// Define LATCH_SCHED_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module latch_bank_sched
    import latch_sched_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int AW        = 3,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic                     clc,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*AW-1:0]       req_addr_i,
    input  logic [NREQ*DW-1:0]       req_data_i,
    output logic [NREQ-1:0]          ack_o,
    output logic [DW-1:0]            lat_d_o,
    output logic [(2**AW)-1:0]       lat_en_o,
    output logic                     busy_o,
    output logic [grant_w(NREQ)-1:0] grant_id_o
);
    localparam int DEPTH     = 2**AW;
    localparam int GW        = grant_w(NREQ);
    localparam int PULSE_EFF = at_least(PULSE_CYC, MIN_PULSE_CYC);
    localparam int HOLD_EFF  = at_least(HOLD_CYC, MIN_HOLD_CYC);
    localparam int CW        = cnt_w(PULSE_EFF, HOLD_EFF);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_EFF - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_EFF - 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    lat_d_q;
    logic [DEPTH-1:0] lat_en_q, lat_en_d;
    logic [NREQ-1:0]  ack_q;
    logic             busy_q;
    logic [GW-1:0]    grant_id_q;
    logic [GW-1:0]    arb_ptr, gnt_idx;
    logic             gnt_valid;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;

`ifdef LATCH_SCHED_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    assign arb_ptr  = rr_ptr_q;
    assign rr_ptr_d = (grant_id_q == GW'(NREQ - 1)) ? '0 : grant_id_q + GW'(1);
`endif

    latch_sched_rr_arb #(.NREQ(NREQ)) u_arb (
        .req_i       (req_i),
        .ptr_i       (arb_ptr),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == GW'(i)) begin
                sel_addr = req_addr_i[i*AW +: AW];
                sel_data = req_data_i[i*DW +: DW];
            end
        end
    end

    assign lat_en_d = DEPTH'(1) << addr_q;

    // Gate enables come straight from flops so the latch gates never glitch.
    always_ff @(posedge clc) begin
        if (!rst_n) begin
            // NOTE: state and outputs use <= so every flop samples pre-edge values.
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            lat_d_q    <= '0;
            lat_en_q   <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
`ifndef LATCH_SCHED_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        state_q    <= SETUP;
                        busy_q     <= 1'b1;
                        grant_id_q <= gnt_idx;
                        addr_q     <= sel_addr;
                        lat_d_q    <= sel_data;
                    end
                end
                SETUP: begin
                    state_q  <= PULSE;
                    lat_en_q <= lat_en_d;
                    cnt_q    <= PULSE_LOAD;
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        state_q  <= HOLD;
                        lat_en_q <= '0;
                        cnt_q    <= HOLD_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        ack_q   <= NREQ'(1) << grant_id_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`ifndef LATCH_SCHED_FIXED_PRIO_EN
                    rr_ptr_q <= rr_ptr_d;
`endif
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    lat_en_q <= '0;
                end
            endcase
        end
    end

    assign ack_o      = ack_q;
    assign lat_d_o    = lat_d_q;
    assign lat_en_o   = lat_en_q;
    assign busy_o     = busy_q;
    assign grant_id_o = grant_id_q;

endmodule

// File: doc/latch_bank_sched.md
Name: latch_bank_sched

Overview:
- Schedules write access to a bank of gated D latches (one DW-bit word per address) shared by NREQ requesters.
- Arbitrates among pending write requests and drives the shared latch data bus.
- Sequences each write as setup, gate pulse, then hold, so data is always stable around the latch gate.
- Sits between the requesting blocks and the latch array; the latch gates are driven only from this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, latch word width.
- AW, 3, address width; bank depth is 2**AW.
- PULSE_CYC, 1, cycles the gate is held high (>=1).
- HOLD_CYC, 1, cycles data is held after the gate falls (>=1).

Ports:
- clc, in, 1: clock, rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- req, in, NREQ: per-requester write request, level, held until ack.
- req_addr, in, NREQ*AW: packed addresses; requester i uses slice [i*AW +: AW].
- req_data, in, NREQ*DW: packed data; requester i uses slice [i*DW +: DW].
- ack, out, NREQ: one-hot completion pulse, one cycle wide.
- lat_d, out, DW: shared latch data bus.
- lat_en, out, 2**AW: one-hot latch gate enables.
- busy, out, 1: high in any state other than IDLE.
- grant_id, out, $clog2(NREQ): index of the current or last granted requester.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state goes to IDLE; ack=0, lat_en=0, lat_d=0, busy=0, grant_id=0.
  - Round-robin pointer goes to 0.
- All outputs are registered. lat_en must be glitch-free because it gates latches.
- FSM states: IDLE, SETUP, PULSE, HOLD, DONE.
- IDLE:
  - If any req bit is high, grant the first requester at or after the RR pointer (wrapping).
  - Capture that requester's address and data into lat_d and an internal address register, set grant_id, go to SETUP.
  - If no req bit is high, stay in IDLE.
- SETUP: 1 cycle; lat_d valid, lat_en=0; go to PULSE.
- PULSE: lat_en[addr]=1 for PULSE_CYC cycles; all other lat_en bits 0; go to HOLD.
- HOLD: lat_en=0 and lat_d unchanged for HOLD_CYC cycles; go to DONE.
- DONE:
  - ack[grant_id]=1 for exactly one cycle.
  - RR pointer becomes (grant_id+1) mod NREQ.
  - Go to IDLE.
- Latency: req sampled at edge t produces ack high in cycle t+3+PULSE_CYC+HOLD_CYC-1. With defaults, ack is high in the 4th cycle after grant, which is 5 cycles per transaction including IDLE.
- lat_d is stable from SETUP through the end of HOLD.
- Requester rules:
  - Must keep req, addr and data stable until ack.
  - Must drop req in the cycle after ack; otherwise req is re-arbitrated as a new request.
- Requests arriving while busy wait. They are not lost because req is a level.
- Dropping req before ack is a protocol violation. The captured write still completes and ack is still issued.
- Several requests in the same IDLE cycle: RR order decides. NREQ continuous requesters are each served once per NREQ transactions.
- Back-to-back: DONE to IDLE to SETUP. There is always exactly one IDLE cycle between transactions.
- Reset mid-transaction, including during PULSE: lat_en drops to 0 at that edge, no ack is issued, and the partially written latch content is undefined.
- Internal cycle counter is sized $clog2(max(PULSE_CYC,HOLD_CYC)+1). It is reloaded on each state entry and never wraps.

Optional Feature:
- Macro: LATCH_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The RR pointer is removed and grant_id ignores transaction history.
- Undefined (default): round-robin as described above.
- Timing and outputs are identical in both cases.

Decomposition:
- Package latch_sched_pkg holds:
  - the state enum (IDLE, SETUP, PULSE, HOLD, DONE);
  - a grant-index width function;
  - parameter-check constants (PULSE_CYC>=1, HOLD_CYC>=1).
- One sub-module, latch_sched_rr_arb:
  - inputs: req vector and pointer; outputs: grant valid and grant index;
  - combinational;
  - contains the LATCH_SCHED_FIXED_PRIO_EN switch.

Test Plan:
- Reset, then req=4'b0000 for 10 cycles -> busy=0, lat_en=0, ack=0 throughout.
- req[2]=1, addr=3'd5, data=8'hA5 (defaults):
  - lat_d=8'hA5 one cycle before lat_en=8'b0010_0000, which is high for 1 cycle;
  - lat_d still 8'hA5 one cycle after lat_en falls;
  - ack=4'b0100 in the next cycle.
- req=4'b1111 held, each requester dropping req after its ack -> grant order 0,1,2,3, one IDLE cycle between transactions. With the macro defined and each requester re-raising req immediately, requester 0 is granted every time.
- PULSE_CYC=3, HOLD_CYC=2, single req[1] -> lat_en high for exactly 3 cycles, data stable for 2 further cycles, then ack[1].
- rst_n=0 asserted during PULSE -> lat_en=0 and busy=0 after that edge; no ack pulse; a fresh req after reset is served normally from RR pointer 0.
- req[3] held high across its ack -> served a second time, only after the other pending requests in RR order.
